// File: rtl/uart_frame_producer.sv
// UART TX frame producer: streams "<hdr>,<arg1>,<arg2>*\r\n" byte by byte
// over valid/ready, with unsigned 32-bit arguments rendered in decimal.
module uart_frame_producer #(
  parameter int         MAX_HDR_LEN = 8,
  parameter logic [7:0] SEP_CHAR    = 8'h2C,
  parameter logic [7:0] TERM_CHAR   = 8'h2A,
  parameter bit         APPEND_CRLF = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               send_req,
  input  logic [MAX_HDR_LEN*8-1:0]           hdr_chars,
  input  logic [$clog2(MAX_HDR_LEN+1)-1:0]   hdr_len,
  input  logic [1:0]                         arg_count,
  input  logic [31:0]                        arg1,
  input  logic [31:0]                        arg2,
  output logic [7:0]                         tx_data,
  output logic                               tx_valid,
  input  logic                               tx_ready,
  output logic                               busy,
  output logic                               done,
  output logic                               req_dropped
);

  localparam int HLW = $clog2(MAX_HDR_LEN+1);
  localparam logic [HLW-1:0] HMAX = HLW'(MAX_HDR_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_SEP, S_CONV, S_DIG, S_TERM, S_CR, S_LF
  } state_t;

  state_t                   state_q, state_d;
  logic [MAX_HDR_LEN*8-1:0] hdr_q, hdr_d;
  logic [HLW-1:0]           hlen_q, hlen_d;
  logic [HLW-1:0]           idx_q, idx_d;
  logic [1:0]               argn_q, argn_d;
  logic                     argk_q, argk_d;
  logic [31:0]              a1_q, a1_d;
  logic [31:0]              a2_q, a2_d;
  logic [31:0]              rem_q, rem_d;
  logic [3:0]               p_q, p_d;
  logic [3:0]               dig_q, dig_d;
  logic                     emit_q, emit_d;
  logic                     done_q, done_d;
  logic                     drop_q, drop_d;
  logic                     xfer;
  logic [31:0]              pw;

  function automatic logic [31:0] pow10(input logic [3:0] p);
    case (p)
      4'd0: pow10 = 32'd1;
      4'd1: pow10 = 32'd10;
      4'd2: pow10 = 32'd100;
      4'd3: pow10 = 32'd1000;
      4'd4: pow10 = 32'd10000;
      4'd5: pow10 = 32'd100000;
      4'd6: pow10 = 32'd1000000;
      4'd7: pow10 = 32'd10000000;
      4'd8: pow10 = 32'd100000000;
      4'd9: pow10 = 32'd1000000000;
      default: pow10 = 32'd1;
    endcase
  endfunction

  assign pw = pow10(p_q);
  assign tx_valid = (state_q != S_IDLE) && (state_q != S_CONV);
  assign xfer = tx_valid & tx_ready;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign req_dropped = drop_q;

  always_comb begin
    tx_data = '0;
    unique case (state_q)
      S_HDR:  tx_data = hdr_q[{idx_q, 3'b000} +: 8];
      S_SEP:  tx_data = SEP_CHAR;
      S_DIG:  tx_data = 8'h30 + {4'h0, dig_q};
      S_TERM: tx_data = TERM_CHAR;
      S_CR:   tx_data = 8'h0D;
      S_LF:   tx_data = 8'h0A;
      default: tx_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    hlen_d  = hlen_q;
    idx_d   = idx_q;
    argn_d  = argn_q;
    argk_d  = argk_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    rem_d   = rem_q;
    p_d     = p_q;
    dig_d   = dig_q;
    emit_d  = emit_q;
    done_d  = 1'b0;
    drop_d  = send_req && (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: if (send_req) begin
        hdr_d  = hdr_chars;
        hlen_d = (hdr_len > HMAX) ? HMAX : hdr_len;
        argn_d = (arg_count == 2'd3) ? 2'd2 : arg_count;
        a1_d   = arg1;
        a2_d   = arg2;
        idx_d  = '0;
        argk_d = 1'b0;
        if (hlen_d != '0)       state_d = S_HDR;
        else if (argn_d != '0)  state_d = S_SEP;
        else                    state_d = S_TERM;
      end
      S_HDR: if (xfer) begin
        idx_d = idx_q + HLW'(1);
        if (idx_q == hlen_q - HLW'(1))
          state_d = (argn_q != '0) ? S_SEP : S_TERM;
      end
      S_SEP: if (xfer) begin
        rem_d   = argk_q ? a2_q : a1_q;
        p_d     = 4'd9;
        dig_d   = '0;
        emit_d  = 1'b0;
        state_d = S_CONV;
      end
      // One subtract per cycle; a digit is final once rem < 10^p
      S_CONV: begin
        if (rem_q >= pw) begin
          rem_d = rem_q - pw;
          dig_d = dig_q + 4'd1;
        end else if (dig_q != '0 || emit_q || p_q == '0) begin
          state_d = S_DIG;
        end else begin
          p_d = p_q - 4'd1;
        end
      end
      S_DIG: if (xfer) begin
        emit_d = 1'b1;
        dig_d  = '0;
        if (p_q == '0) begin
          argk_d  = 1'b1;
          state_d = (!argk_q && argn_q == 2'd2) ? S_SEP : S_TERM;
        end else begin
          p_d     = p_q - 4'd1;
          state_d = S_CONV;
        end
      end
      S_TERM: if (xfer) begin
        if (APPEND_CRLF) begin
          state_d = S_CR;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_CR: if (xfer) state_d = S_LF;
      S_LF: if (xfer) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hdr_q   <= '0;
      hlen_q  <= '0;
      idx_q   <= '0;
      argn_q  <= '0;
      argk_q  <= 1'b0;
      a1_q    <= '0;
      a2_q    <= '0;
      rem_q   <= '0;
      p_q     <= '0;
      dig_q   <= '0;
      emit_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      hlen_q  <= hlen_d;
      idx_q   <= idx_d;
      argn_q  <= argn_d;
      argk_q  <= argk_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      rem_q   <= rem_d;
      p_q     <= p_d;
      dig_q   <= dig_d;
      emit_q  <= emit_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

endmodule
